// File: rtl/morse_keyer_if.sv
// Character input handshake and keyer status outputs for morse_keyer.
interface morse_keyer_if;
    logic       in_valid;
    logic [7:0] in_ascii;
    logic       in_ready;
    logic       key;
    logic       busy;
    logic       err;

    modport master (
        output in_valid, in_ascii,
        input  in_ready, key, busy, err
    );

    modport slave (
        input  in_valid, in_ascii,
        output in_ready, key, busy, err
    );
endinterface

// File: rtl/morse_keyer.sv
// ASCII-to-Morse keyer with a registered 24-bit symbol code and UNIT_CYCLES timing.
// Define MORSE_KEYER_FIFO_EN for a 4-entry input FIFO ahead of the translator.

module ascii2morse_lut (
    input  logic [7:0]  ascii_i,
    output logic [23:0] code_o
);
    logic [7:0] up_ascii;

    // Packs len symbols MSB first; pat bit 1 = dash, left-aligned in 5 bits.
    function automatic logic [23:0] pack(input logic [2:0] len, input logic [4:0] pat);
        logic [23:0] c;
        c = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < int'(len)) c[23-3*i -: 3] = {(i == int'(len) - 1), 1'b1, pat[4-i]};
        end
        return c;
    endfunction

    always_comb begin
        up_ascii = ascii_i;
        if (ascii_i >= 8'h61 && ascii_i <= 8'h7a) up_ascii = ascii_i - 8'h20;
    end

    always_comb begin
        case (up_ascii)
            8'h20: code_o = 24'h800000;
            "A":   code_o = pack(3'd2, 5'b01000);
            "B":   code_o = pack(3'd4, 5'b10000);
            "C":   code_o = pack(3'd4, 5'b10100);
            "D":   code_o = pack(3'd3, 5'b10000);
            "E":   code_o = pack(3'd1, 5'b00000);
            "F":   code_o = pack(3'd4, 5'b00100);
            "G":   code_o = pack(3'd3, 5'b11000);
            "H":   code_o = pack(3'd4, 5'b00000);
            "I":   code_o = pack(3'd2, 5'b00000);
            "J":   code_o = pack(3'd4, 5'b01110);
            "K":   code_o = pack(3'd3, 5'b10100);
            "L":   code_o = pack(3'd4, 5'b01000);
            "M":   code_o = pack(3'd2, 5'b11000);
            "N":   code_o = pack(3'd2, 5'b10000);
            "O":   code_o = pack(3'd3, 5'b11100);
            "P":   code_o = pack(3'd4, 5'b01100);
            "Q":   code_o = pack(3'd4, 5'b11010);
            "R":   code_o = pack(3'd3, 5'b01000);
            "S":   code_o = pack(3'd3, 5'b00000);
            "T":   code_o = pack(3'd1, 5'b10000);
            "U":   code_o = pack(3'd3, 5'b00100);
            "V":   code_o = pack(3'd4, 5'b00010);
            "W":   code_o = pack(3'd3, 5'b01100);
            "X":   code_o = pack(3'd4, 5'b10010);
            "Y":   code_o = pack(3'd4, 5'b10110);
            "Z":   code_o = pack(3'd4, 5'b11000);
            "0":   code_o = pack(3'd5, 5'b11111);
            "1":   code_o = pack(3'd5, 5'b01111);
            "2":   code_o = pack(3'd5, 5'b00111);
            "3":   code_o = pack(3'd5, 5'b00011);
            "4":   code_o = pack(3'd5, 5'b00001);
            "5":   code_o = pack(3'd5, 5'b00000);
            "6":   code_o = pack(3'd5, 5'b10000);
            "7":   code_o = pack(3'd5, 5'b11000);
            "8":   code_o = pack(3'd5, 5'b11100);
            "9":   code_o = pack(3'd5, 5'b11110);
            // Unsupported characters key as eight dots and raise err.
            default: code_o = 24'h492496;
        endcase
    end
endmodule

module morse_keyer #(
    parameter int unsigned UNIT_CYCLES = 1000
) (
    input logic          clk,
    input logic          rst,
    morse_keyer_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StMark, StGap, StCgap, StWgap} state_e;

    localparam logic [15:0] UnitLast = 16'(UNIT_CYCLES - 1);
    localparam logic [23:0] BadCode  = 24'h492496;

    state_e      state_q, state_d;
    logic [23:0] code_q, code_d;
    logic [15:0] cyc_q, cyc_d;
    logic [1:0]  units_q, units_d;
    logic        key_q, key_d;
    logic        err_q, err_d;

    logic        load;
    logic        queued;
    logic        ready;
    logic [7:0]  lut_ascii;
    logic [23:0] lut_code;
    logic        unit_end;
    logic [2:0]  sym;

    ascii2morse_lut u_lut (
        .ascii_i (lut_ascii),
        .code_o  (lut_code)
    );

`ifdef MORSE_KEYER_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [7:0] fifo_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       push;

    assign ready     = !rst && (cnt_q != 3'd4);
    assign push      = bus.in_valid && ready;
    assign load      = (state_q == StIdle) && (cnt_q != 3'd0);
    assign queued    = (cnt_q != 3'd0);
    assign lut_ascii = fifo_q[rd_ptr_q];

    always_comb begin
        fifo_d = fifo_q;
        if (push) fifo_d[wr_ptr_q] = bus.in_ascii;
        wr_ptr_d = wr_ptr_q + 2'(push);
        rd_ptr_d = rd_ptr_q + 2'(load);
        cnt_d    = cnt_q + 3'(push) - 3'(load);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign ready     = !rst && (state_q == StIdle);
    assign load      = bus.in_valid && ready;
    assign queued    = 1'b0;
    assign lut_ascii = bus.in_ascii;
`endif

    assign sym      = code_q[23:21];
    assign unit_end = (cyc_q == UnitLast);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        err_d   = 1'b0;
        cyc_d   = cyc_q + 16'd1;
        units_d = units_q;
        if (unit_end) begin
            cyc_d   = '0;
            units_d = units_q + 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    code_d  = lut_code;
                    err_d   = (lut_code == BadCode);
                    state_d = (lut_code[23:21] == 3'b100) ? StWgap : StMark;
                end
            end
            // Dash holds for units 0..2, dot for unit 0 only.
            StMark: begin
                if (unit_end && units_q == (sym[0] ? 2'd2 : 2'd0)) begin
                    state_d = sym[2] ? StCgap : StGap;
                end
            end
            StGap: begin
                if (unit_end) begin
                    code_d  = {code_q[20:0], 3'b000};
                    state_d = StMark;
                end
            end
            StCgap:  if (unit_end && units_q == 2'd2) state_d = StIdle;
            StWgap:  if (unit_end && units_q == 2'd3) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d != state_q || state_q == StIdle) begin
            cyc_d   = '0;
            units_d = '0;
        end
        key_d = (state_d == StMark);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            code_q  <= '0;
            cyc_q   <= '0;
            units_q <= '0;
            key_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cyc_q   <= cyc_d;
            units_q <= units_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready = ready;
    assign bus.key      = key_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != StIdle) || queued;
endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: per-cycle reference model, table of
// key run-length patterns, directed corner sequences and random traffic.
module tb_morse_keyer;
    localparam int unsigned Unit = 2;
`ifdef MORSE_KEYER_FIFO_EN
    localparam bit Fifo = 1'b1;
`else
    localparam bit Fifo = 1'b0;
`endif
    localparam int LoadLat = Fifo ? 1 : 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    morse_keyer_if bus ();

    morse_keyer #(.UNIT_CYCLES(Unit)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: expected key level per cycle of the current character.
    bit         wave[$];
    logic [7:0] mq[$];
    bit         m_key, m_err, m_active;

    string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    string tbl [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----",
                        "..---", "...--", "....-", ".....", "-....", "--...", "---..",
                        "----."};

    typedef struct {
        logic [7:0] ch;
        int         err;
        string      runs;
    } vec_t;
    vec_t vecs[$];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_str(string name, string got, string exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got \"%s\", expected \"%s\" at %0t", name, got, exp, $time);
        end
    endtask

    function automatic string morse_of(logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (c >= 8'h61 && c <= 8'h7a) u = c - 8'h20;
        if (u == 8'h20) return " ";
        for (int i = 0; i < alpha.len(); i++) if (alpha[i] == u) return tbl[i];
        return "";
    endfunction

    task automatic expand(logic [7:0] c);
        string m;
        m = morse_of(c);
        if (m == " ") begin
            repeat (4 * Unit) wave.push_back(1'b0);
            return;
        end
        if (m == "") m = "........";
        for (int i = 0; i < m.len(); i++) begin
            int on;
            int off;
            on  = (m[i] == "-") ? 3 : 1;
            off = (i == m.len() - 1) ? 3 : 1;
            repeat (on * Unit) wave.push_back(1'b1);
            repeat (off * Unit) wave.push_back(1'b0);
        end
    endtask

    task automatic model_reset();
        wave.delete();
        mq.delete();
        m_key    = 1'b0;
        m_err    = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic model_step();
        bit         ready_pre;
        bit         load;
        logic [7:0] ch;
        ready_pre = Fifo ? (mq.size() < 4) : !m_active;
        load = 1'b0;
        ch   = '0;
        if (Fifo) begin
            if (!m_active && mq.size() > 0) begin
                load = 1'b1;
                ch   = mq.pop_front();
            end
            if (bus.in_valid && ready_pre) mq.push_back(bus.in_ascii);
        end else if (bus.in_valid && ready_pre) begin
            load = 1'b1;
            ch   = bus.in_ascii;
        end
        m_err = 1'b0;
        if (wave.size() > 0) begin
            m_key    = wave.pop_front();
            m_active = 1'b1;
        end else if (load) begin
            expand(ch);
            m_key    = wave.pop_front();
            m_active = 1'b1;
            m_err    = (morse_of(ch) == "");
        end else begin
            m_key    = 1'b0;
            m_active = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check("key", bus.key, m_key);
        check("err", bus.err, m_err);
        check("busy", bus.busy, m_active || mq.size() > 0);
        check("in_ready", bus.in_ready, rst ? 1'b0 : (Fifo ? (mq.size() < 4) : !m_active));
    endtask

    task automatic send(logic [7:0] c);
        bit acc;
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_ascii = c;
        for (int i = 0; i < 200; i++) begin
            acc = bus.in_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_idle(int budget);
        for (int i = 0; i < budget && bus.busy; i++) tick();
        if (bus.busy) check("idle_timeout", 1, 0);
    endtask

    task automatic add_vec(logic [7:0] c, int e, string r);
        vec_t v;
        v.ch   = c;
        v.err  = e;
        v.runs = r;
        vecs.push_back(v);
    endtask

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 5))
            0:       return 8'h41 + 8'($urandom_range(0, 25));
            1:       return 8'h61 + 8'($urandom_range(0, 25));
            2:       return 8'h30 + 8'($urandom_range(0, 9));
            3:       return 8'h20;
            4:       return 8'($urandom_range(0, 255));
            default: return 8'h23;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit  ks[$];
        bit  bs[$];
        int  errs, lead, run;
        int  highs, first_high, last_high, last_busy, acc_n;
        bit  acc, pending;
        string r;

        add_vec(8'h45, 0, "26");
        add_vec(8'h61, 0, "2266");
        add_vec(8'h23, 1, "2222222222222226");
        add_vec("T", 0, "66");
        add_vec("M", 0, "6266");
        add_vec("5", 0, "2222222226");
        add_vec("0", 0, "6262626266");

        bus.in_valid = 1'b0;
        bus.in_ascii = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_key", bus.key, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        tick();

        foreach (vecs[v]) begin
            send(vecs[v].ch);
            ks.delete();
            errs = 0;
            for (int i = 0; i < 300 && bus.busy; i++) begin
                ks.push_back(bus.key);
                errs += int'(bus.err);
                tick();
            end
            if (bus.busy) check("vec_timeout", 1, 0);
            lead = 0;
            while (lead < ks.size() && ks[lead] == 1'b0) lead++;
            check($sformatf("lead_%c", vecs[v].ch), lead, LoadLat);
            r = "";
            run = 1;
            for (int i = lead + 1; i < ks.size(); i++) begin
                if (ks[i] == ks[i-1]) run++;
                else begin
                    r = {r, $sformatf("%0d", run)};
                    run = 1;
                end
            end
            if (lead < ks.size()) r = {r, $sformatf("%0d", run)};
            check_str($sformatf("runs_%c", vecs[v].ch), r, vecs[v].runs);
            check($sformatf("err_cycles_%c", vecs[v].ch), errs, vecs[v].err);
        end

        // 'T' followed immediately by a word space.
        send("T");
        bus.in_valid = 1'b1;
        bus.in_ascii = 8'h20;
        pending = 1'b1;
        ks.delete();
        bs.delete();
        for (int i = 0; i < 40; i++) begin
            ks.push_back(bus.key);
            bs.push_back(bus.busy);
            acc = bus.in_ready;
            tick();
            if (acc && pending) begin
                bus.in_valid = 1'b0;
                pending = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        highs = 0;
        first_high = -1;
        last_high = -1;
        last_busy = -1;
        foreach (ks[i]) begin
            if (ks[i]) begin
                highs++;
                if (first_high < 0) first_high = i;
                last_high = i;
            end
            if (bs[i]) last_busy = i;
        end
        check("ts_highs", highs, 6);
        check("ts_first_high", first_high, LoadLat);
        check("ts_high_run", last_high - first_high + 1, 6);
        check("ts_span", last_busy - first_high + 1, 21);
        wait_idle(100);

        // Asynchronous reset in the middle of a dash of 'O'.
        send("O");
        for (int i = 0; i < 10 && !m_key; i++) tick();
        tick();
        check("pre_rst_key", bus.key, 1);
        rst = 1'b1;
        #1;
        check("async_rst_key", bus.key, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_in_ready", bus.in_ready, 0);
        model_reset();
        tick();
        rst = 1'b0;
        #1;
        check("rel_in_ready", bus.in_ready, 1);
        check("rel_busy", bus.busy, 0);
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            highs += int'(bus.key);
        end
        check("no_resume_highs", highs, 0);

`ifdef MORSE_KEYER_FIFO_EN
        r = "ETAIMS";
        acc_n = 0;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.in_ascii = r[k];
            acc = bus.in_ready;
            tick();
            acc_n += int'(acc);
        end
        bus.in_valid = 1'b0;
        check("fifo_accepted", acc_n, 5);
        check("fifo_full_ready", bus.in_ready, 0);
        wait_idle(1000);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b1;
                bus.in_ascii = rand_char();
            end else begin
                bus.in_valid = 1'b0;
                bus.in_ascii = 8'($urandom_range(0, 255));
            end
            tick();
        end
        bus.in_valid = 1'b0;
        wait_idle(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
